// File: rtl/mux32_pkg.sv
// Shared constants for the mux_32 word selector.
// Holds the data width default and the B-select counter width/saturation value.
package mux32_pkg;
  localparam int MUX32_WIDTH = 32;
  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
endpackage

// File: rtl/mux_32_if.sv
// Operand/result bundle for mux_32; the slave modport is the selector side.
// SelBCount exists only when MUX32_SELCOUNT_EN is defined.
interface mux_32_if
  import mux32_pkg::*;
#(
  parameter int WIDTH = MUX32_WIDTH
);
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic             CtlSig;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] OutputReg;
  logic             SelReg;
`ifdef MUX32_SELCOUNT_EN
  logic [CNT_W-1:0] SelBCount;
`endif

  modport master (
    output InputA, InputB, CtlSig,
`ifdef MUX32_SELCOUNT_EN
    input  SelBCount,
`endif
    input  Output, OutputReg, SelReg
  );

  modport slave (
    input  InputA, InputB, CtlSig,
`ifdef MUX32_SELCOUNT_EN
    output SelBCount,
`endif
    output Output, OutputReg, SelReg
  );
endinterface

// File: rtl/mux2_slice.sv
// Parameterized combinational 2:1 selector, zero latency, no handshake.
// An unknown select yields an all-X word rather than falling back to either input.
module mux2_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  always_comb begin
    y = 'x;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end
endmodule

// File: rtl/mux_32.sv
// Two-input word selector: combinational Output plus one-cycle registered copy and select.
// Optional saturating B-select counter on SelBCount when MUX32_SELCOUNT_EN is defined; no backpressure.
module mux_32
  import mux32_pkg::*;
#(
  parameter int WIDTH = MUX32_WIDTH
) (
  input logic     clk,
  input logic     rst_n,
  mux_32_if.slave bus
);
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] out_reg_d, out_reg_q;
  logic             sel_reg_d, sel_reg_q;

  mux2_slice #(.W(WIDTH)) u_slice (
    .a   (bus.InputA),
    .b   (bus.InputB),
    .sel (bus.CtlSig),
    .y   (sel_word)
  );

  assign bus.Output = sel_word;

  always_comb begin
    out_reg_d = sel_word;
    sel_reg_d = bus.CtlSig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg_q <= '0;
      sel_reg_q <= 1'b0;
    end else begin
      out_reg_q <= out_reg_d;
      sel_reg_q <= sel_reg_d;
    end
  end

  assign bus.OutputReg = out_reg_q;
  assign bus.SelReg    = sel_reg_q;

`ifdef MUX32_SELCOUNT_EN
  logic [CNT_W-1:0] sel_cnt_d, sel_cnt_q;

  // Holds at the saturation value instead of wrapping back to zero.
  always_comb begin
    sel_cnt_d = sel_cnt_q;
    if (bus.CtlSig && (sel_cnt_q != CNT_SAT)) begin
      sel_cnt_d = sel_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cnt_q <= '0;
    end else begin
      sel_cnt_q <= sel_cnt_d;
    end
  end

  assign bus.SelBCount = sel_cnt_q;
`endif
endmodule

// File: tb/tb_mux_32.sv
// Directed bench for mux_32: combinational select, registered stage, async reset.
// Counter saturation steps are included when MUX32_SELCOUNT_EN is defined.
module tb_mux_32;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_32_if #(.WIDTH(32)) bus ();

  mux_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    total = 0;
    bad   = 0;

    // Reset state with all-zero inputs
    rst_n      = 1'b0;
    bus.InputA = 32'h0000_0000;
    bus.InputB = 32'h0000_0000;
    bus.CtlSig = 1'b0;
    #2;
    chk("zero_out", bus.Output, 32'h0000_0000);
    chk("rst_outreg", bus.OutputReg, 32'h0000_0000);
    chk("rst_selreg", {31'd0, bus.SelReg}, 32'd0);
`ifdef MUX32_SELCOUNT_EN
    chk("rst_cnt", bus.SelBCount, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Select A / select B without any clock edge in between
    @(negedge clk);
    bus.InputA = 32'h1234_5678;
    bus.InputB = 32'h9ABC_DEF0;
    bus.CtlSig = 1'b0;
    #1 chk("sel_a", bus.Output, 32'h1234_5678);
    bus.CtlSig = 1'b1;
    #1 chk("sel_b", bus.Output, 32'h9ABC_DEF0);
    bus.CtlSig = 1'b0;
    #1 chk("sel_a_again", bus.Output, 32'h1234_5678);

    // Random pairs; B held through an edge so the registered copy is checked too
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ra = $urandom();
      rb = $urandom();
      bus.InputA = ra;
      bus.InputB = rb;
      bus.CtlSig = 1'b0;
      #1 chk("rand_a", bus.Output, ra);
      bus.CtlSig = 1'b1;
      #1 chk("rand_b", bus.Output, rb);
      @(posedge clk);
      #1;
      chk("rand_reg", bus.OutputReg, rb);
      chk("rand_selreg", {31'd0, bus.SelReg}, 32'd1);
    end

    // Width boundary: all ones against all zeros
    @(negedge clk);
    bus.InputA = 32'h0000_0000;
    bus.InputB = 32'hFFFF_FFFF;
    bus.CtlSig = 1'b1;
    #1 chk("ones_b", bus.Output, 32'hFFFF_FFFF);
    bus.CtlSig = 1'b0;
    #1 chk("zeros_a", bus.Output, 32'h0000_0000);

    // Registered path: previous value held until the capturing edge
    @(negedge clk);
    bus.InputA = 32'h1111_1111;
    bus.InputB = 32'hDEAD_BEEF;
    bus.CtlSig = 1'b0;
    @(posedge clk);
    #1;
    chk("reg_prev", bus.OutputReg, 32'h1111_1111);
    chk("selreg_prev", {31'd0, bus.SelReg}, 32'd0);
    @(negedge clk);
    bus.CtlSig = 1'b1;
    #1 chk("reg_before_edge", bus.OutputReg, 32'h1111_1111);
    chk("selreg_before_edge", {31'd0, bus.SelReg}, 32'd0);
    @(posedge clk);
    #1;
    chk("reg_beef", bus.OutputReg, 32'hDEAD_BEEF);
    chk("selreg_one", {31'd0, bus.SelReg}, 32'd1);

    // Async reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outreg", bus.OutputReg, 32'h0000_0000);
    chk("arst_selreg", {31'd0, bus.SelReg}, 32'd0);
    chk("arst_out", bus.Output, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 chk("arst_hold", bus.OutputReg, 32'h0000_0000);
    bus.CtlSig = 1'b0;
    #1 chk("arst_track", bus.Output, 32'h1111_1111);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_noedge", bus.OutputReg, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("post_rst_cap", bus.OutputReg, 32'h1111_1111);
    chk("post_rst_sel", {31'd0, bus.SelReg}, 32'd0);

`ifdef MUX32_SELCOUNT_EN
    // Counter: 5 B edges then 3 A edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_clr", bus.SelBCount, 32'd0);
    bus.CtlSig = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.CtlSig = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cnt_five", bus.SelBCount, 32'd5);

    // Saturation at all ones
    @(negedge clk);
    force dut.sel_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.sel_cnt_q;
    bus.CtlSig = 1'b1;
    @(posedge clk);
    #1 chk("cnt_max", bus.SelBCount, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 chk("cnt_nowrap", bus.SelBCount, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
